// File: rtl/jr_counter_pkg.sv
// ---------------------------------------------------------------------------
// jr_counter_pkg
//   Shared constants and step functions for the Johnson/ring shift counter.
//   All functions work on a 64-bit container (the widest legal counter).
//   Callers cast the result down to their own WIDTH, so one package serves
//   every parameterisation.
//
//   Contents:
//     MODE_RING / MODE_JOHNSON : encodings of the j_r mode select
//     seed(mode, width)        : first state of a mode's sequence
//     johnson_next(s, width)   : twisted-ring step
//     ring_next(s, width)      : rotate-left step
// ---------------------------------------------------------------------------
package jr_counter_pkg;

   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;

   localparam int MAX_WIDTH = 64;

   typedef logic [MAX_WIDTH-1:0] wide_t;

   // Johnson starts from all-zeros; ring starts from a single one in bit 0.
   // The width mask keeps the ring seed inside the counter for any width.
   function automatic wide_t seed(input logic mode, input int width);
      wide_t widthMask;
      widthMask = (wide_t'(1) << width) - wide_t'(1);
      if (mode == MODE_JOHNSON) begin
         return '0;
      end
      return wide_t'(1) & widthMask;
   endfunction

   // The MSB position is computed in 6 bits. For width 64, 6'(64-1) is 63,
   // so the full container is handled without a wider index.
   function automatic wide_t johnson_next(input wide_t s, input int width);
      wide_t      r;
      logic [5:0] msb;
      msb  = 6'(width - 1);
      r    = s << 1;
      r[0] = ~s[msb];
      return r;
   endfunction

   function automatic wide_t ring_next(input wide_t s, input int width);
      wide_t      r;
      logic [5:0] msb;
      msb  = 6'(width - 1);
      r    = s << 1;
      r[0] = s[msb];
      return r;
   endfunction

endpackage

// File: rtl/jr_counter_legal_chk.sv
// ---------------------------------------------------------------------------
// jr_counter_legal_chk
//   Combinational legality check of the counter state for the current mode.
//   This module is only instantiated when JR_COUNTER_SELF_CORRECT_EN is defined.
//
//   Ports:
//     mode_i  : 1 = Johnson, 0 = ring
//     state_i : counter state to examine (WIDTH bits)
//     legal_o : 1 when state_i belongs to the sequence of mode_i
//
//   Ring legal    : exactly one bit set.
//   Johnson legal : at most one 0/1 boundary between neighbouring bits.
//                   The MSB-to-LSB wrap is not counted, so 0..01..1,
//                   1..10..0, all-0 and all-1 all pass.
// ---------------------------------------------------------------------------
module jr_counter_legal_chk
   import jr_counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             mode_i,
   input  logic [WIDTH-1:0] state_i,
   output logic             legal_o
);

   // Count the set bits for the ring test. Count the adjacent-bit
   // transitions for the Johnson test. Only the count for the active mode
   // decides the result.
   always_comb begin
      int onesCount;
      int transitionCount;
      onesCount       = 0;
      transitionCount = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (state_i[i]) begin
            onesCount++;
         end
      end
      for (int i = 1; i < WIDTH; i++) begin
         if (state_i[i] != state_i[i-1]) begin
            transitionCount++;
         end
      end
      if (mode_i == MODE_JOHNSON) begin
         legal_o = (transitionCount <= 1);
      end else begin
         legal_o = (onesCount == 1);
      end
   end

endmodule

// File: rtl/jr_counter.sv
// ---------------------------------------------------------------------------
// jr_counter
//   Shift counter that produces either a Johnson (twisted-ring) sequence
//   or a one-hot ring sequence. j_r selects the mode on every cycle, and
//   one WIDTH-bit register drives out directly.
//
//   Parameters:
//     WIDTH : counter width, 2..64 (default 4)
//
//   Ports:
//     clk  : rising-edge clock
//     rstn : asynchronous active-low reset. Release must be synchronous to clk.
//     j_r  : mode select, 1 = Johnson, 0 = ring
//     out  : registered counter state
//
//   Configuration macro:
//     JR_COUNTER_SELF_CORRECT_EN : when defined, an illegal state is replaced
//                                  by the seed of the current mode on the
//                                  next edge instead of being shifted.
//
//   Next-state priority: reset > mode switch > self-correct > step.
// ---------------------------------------------------------------------------
module jr_counter
   import jr_counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             j_r,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;
   logic             mode_q;

   logic [WIDTH-1:0] seedNow;
   logic [WIDTH-1:0] johnsonStep;
   logic [WIDTH-1:0] ringStep;

`ifdef JR_COUNTER_SELF_CORRECT_EN
   logic stateLegal;

   // Legality is judged against the mode the register was built in. The
   // correction path is only used when there is no mode switch, and in that
   // case mode_q equals j_r.
   jr_counter_legal_chk #(
      .WIDTH   (WIDTH)
   ) u_legal_chk (
      .mode_i  (mode_q),
      .state_i (state_q),
      .legal_o (stateLegal)
   );
`endif

   // Candidate next states, evaluated in the 64-bit container and then cast
   // back to the counter width.
   always_comb begin
      seedNow     = WIDTH'(seed(j_r, WIDTH));
      johnsonStep = WIDTH'(johnson_next(wide_t'(state_q), WIDTH));
      ringStep    = WIDTH'(ring_next(wide_t'(state_q), WIDTH));
   end

   // A mode change restarts the new sequence from its seed, with no step on
   // that edge. Otherwise the counter steps in the current mode, unless
   // self-correction is built in and the state is illegal.
   always_comb begin
      state_d = state_q;
      if (j_r != mode_q) begin
         state_d = seedNow;
      end
`ifdef JR_COUNTER_SELF_CORRECT_EN
      else if (!stateLegal) begin
         state_d = seedNow;
      end
`endif
      else if (j_r == MODE_JOHNSON) begin
         state_d = johnsonStep;
      end else begin
         state_d = ringStep;
      end
   end

   // While rstn is low the register loads the seed of the j_r value
   // presented at that moment. mode_q captures j_r on every edge, so a
   // switch is detected exactly once.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= seedNow;
         mode_q  <= j_r;
      end else begin
         state_q <= state_d;
         mode_q  <= j_r;
      end
   end

   assign out = state_q;

endmodule

// File: tb/tb_jr_counter.sv
// ---------------------------------------------------------------------------
// tb_jr_counter
//   Directed bench for jr_counter. A WIDTH=4 instance covers the Johnson and
//   ring runs, mode switching, async reset and illegal-state handling. A
//   WIDTH=8 instance covers the full Johnson period.
//   When JR_COUNTER_SELF_CORRECT_EN is defined, the illegal-state
//   expectations follow that build.
// ---------------------------------------------------------------------------
module tb_jr_counter;

   logic       clk;
   logic       rstn;
   logic       jR;
   logic [3:0] out4;

   logic       rstn8;
   logic       jR8;
   logic [7:0] out8;

   int errors;
   int checks;

   jr_counter #(
      .WIDTH (4)
   ) dut (
      .clk   (clk),
      .rstn  (rstn),
      .j_r   (jR),
      .out   (out4)
   );

   jr_counter #(
      .WIDTH (8)
   ) dut8 (
      .clk   (clk),
      .rstn  (rstn8),
      .j_r   (jR8),
      .out   (out8)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every comparison passes through here. A failed assertion counts the
   // failure and reports the tag with the observed and expected values.
   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   // Wait for one active edge, then sample 1 time unit later.
   task automatic applyStimulus(input string tag, input logic [3:0] expected);
      @(posedge clk);
      #1;
      checkOutput(tag, {4'b0, out4}, {4'b0, expected});
   endtask

   initial begin
      logic [3:0] johnsonSeq [9];
      logic [3:0] ringSeq    [5];
      logic [7:0] exp8;
      logic [7:0] seen8      [16];
      logic       dup;

      errors = 0;
      checks = 0;
      rstn   = 1'b0;
      jR     = 1'b1;
      rstn8  = 1'b0;
      jR8    = 1'b1;

      johnsonSeq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                     4'b1100, 4'b1000, 4'b0000, 4'b0001};
      ringSeq    = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

      // Johnson reset state.
      #1;
      checkOutput("johnson_reset", {4'b0, out4}, 8'b0000_0000);
      checkOutput("w8_reset", out8, 8'b0000_0000);

      // Johnson run: release the reset, then 9 edges.
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 9; i++) begin
         applyStimulus($sformatf("johnson_step%0d", i), johnsonSeq[i]);
      end

      // Advance to 1100, then assert the reset between edges.
      applyStimulus("johnson_pre_rst0", 4'b0011);
      applyStimulus("johnson_pre_rst1", 4'b0111);
      applyStimulus("johnson_pre_rst2", 4'b1111);
      applyStimulus("johnson_pre_rst3", 4'b1110);
      applyStimulus("johnson_pre_rst4", 4'b1100);
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("async_rst_immediate", {4'b0, out4}, 8'b0000_0000);
      applyStimulus("async_rst_held", 4'b0000);
      @(negedge clk);
      rstn = 1'b1;
      applyStimulus("after_rst_release", 4'b0001);

      // Ring run: select ring mode, then assert the reset.
      @(negedge clk);
      jR   = 1'b0;
      rstn = 1'b0;
      #1;
      checkOutput("ring_reset", {4'b0, out4}, 8'b0000_0001);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         applyStimulus($sformatf("ring_step%0d", i), ringSeq[i]);
      end

      // Switch to Johnson and run up to 0111.
      @(negedge clk);
      jR = 1'b1;
      applyStimulus("switch_to_johnson", 4'b0000);
      applyStimulus("johnson_run0", 4'b0001);
      applyStimulus("johnson_run1", 4'b0011);
      applyStimulus("johnson_run2", 4'b0111);

      // Switch mid-run to ring, then back to Johnson.
      @(negedge clk);
      jR = 1'b0;
      applyStimulus("switch_to_ring", 4'b0001);
      applyStimulus("ring_after_switch0", 4'b0010);
      applyStimulus("ring_after_switch1", 4'b0100);
      @(negedge clk);
      jR = 1'b1;
      applyStimulus("switch_back_johnson", 4'b0000);
      applyStimulus("johnson_after_switch", 4'b0001);

      // Illegal Johnson state 0101.
      @(negedge clk);
      force dut.state_q = 4'b0101;
      #1;
      release dut.state_q;
`ifdef JR_COUNTER_SELF_CORRECT_EN
      applyStimulus("johnson_illegal", 4'b0000);
      applyStimulus("johnson_recovered", 4'b0001);
`else
      applyStimulus("johnson_illegal", 4'b1011);
      applyStimulus("johnson_illegal_next", 4'b0110);
`endif

      // Illegal ring state 0110.
      @(negedge clk);
      jR = 1'b0;
      applyStimulus("ring_switch_for_illegal", 4'b0001);
      @(negedge clk);
      force dut.state_q = 4'b0110;
      #1;
      release dut.state_q;
`ifdef JR_COUNTER_SELF_CORRECT_EN
      applyStimulus("ring_illegal", 4'b0001);
`else
      applyStimulus("ring_illegal", 4'b1100);
`endif

      // WIDTH=8 Johnson full period.
      @(negedge clk);
      rstn8 = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         if (k <= 8) begin
            exp8 = 8'((9'd1 << k) - 9'd1);
         end else begin
            exp8 = 8'hFF << (k - 8);
         end
         @(posedge clk);
         #1;
         seen8[k-1] = out8;
         checkOutput($sformatf("w8_step%0d", k), out8, exp8);
      end

      // No repeated state within the 16-state period.
      dup = 1'b0;
      for (int a = 0; a < 16; a++) begin
         for (int b = a + 1; b < 16; b++) begin
            if (seen8[a] === seen8[b]) begin
               dup = 1'b1;
            end
         end
      end
      checkOutput("w8_unique", {7'b0, dup}, 8'b0000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
